inst_mem_loader: RTL and testbench

- Writer side of the instruction-memory write port (WriteData / WriteEnable / word address).
- Accepts a byte stream from a host link (UART/JTAG bridge). Assembles big-endian 32-bit instruction words and issues one write pulse per word into instruction memory.
- Holds the processor (PC and fetch) in reset until the program image is fully written.

---
 rtl/inst_mem_loader_if.sv | 24 ++
 rtl/inst_mem_loader.sv | 114 +++++++++++
 tb/tb_inst_mem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Host byte stream in, instruction-memory write port and CPU hold out.
// The master side is the host/bench and the slave side is the loader.
interface inst_mem_loader_if;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        WriteEnable;
    logic        Done;
    logic        Error;
    logic        CpuHold;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, WriteAddress, WriteData, WriteEnable, Done, Error, CpuHold
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, WriteAddress, WriteData, WriteEnable, Done, Error, CpuHold
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads a program image into instruction memory from a 16-bit word-count header
// followed by big-endian 32-bit words, and keeps the CPU held until the load finishes.
module inst_mem_loader #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic               i_clk,
    input logic               i_rst,
    inst_mem_loader_if.slave  bus
);
    localparam int          IDXW = $clog2(MEM_WORDS + 1);
    localparam logic [31:0] MAXW = MEM_WORDS;

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERROR} state_t;

    state_t            r_state, w_next;
    logic [15:0]       r_count;
    logic [IDXW-1:0]   r_idx;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_part;
    logic [31:0]       r_waddr, r_wdata;
    logic              r_we, r_done, r_err;

    logic              w_rx_state, w_xfer, w_word_done, w_last_word, w_too_big;
    logic [15:0]       w_hdr_count;

    // Ready is withheld during Start so the dropped byte is not seen as taken.
    assign w_rx_state  = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
    assign bus.ByteReady = w_rx_state && !bus.Start && !i_rst;
    assign w_xfer      = bus.ByteValid && bus.ByteReady;

    assign w_hdr_count = {r_count[15:8], bus.ByteIn};
    assign w_too_big   = {16'h0, w_hdr_count} > MAXW;
    assign w_word_done = w_xfer && (r_state == DATA) && (r_bcnt == 2'd3);
    assign w_last_word = ({{(32-IDXW){1'b0}}, r_idx} + 32'd1) == {16'h0, r_count};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= HDR_HI;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.Start) begin
            w_next = HDR_HI;
        end else begin
            case (r_state)
                HDR_HI: if (w_xfer) w_next = HDR_LO;
                HDR_LO: if (w_xfer) begin
                    if (w_hdr_count == 16'd0) w_next = DONE;
                    else if (w_too_big)       w_next = ERROR;
                    else                      w_next = DATA;
                end
                DATA:   if (w_word_done && w_last_word) w_next = DONE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_part  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // A strobe registered on the previous edge always completes, even across Start.
            r_we <= 1'b0;
            if (bus.Start) begin
                r_idx  <= '0;
                r_bcnt <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_xfer) begin
                case (r_state)
                    HDR_HI: r_count[15:8] <= bus.ByteIn;
                    HDR_LO: begin
                        r_count[7:0] <= bus.ByteIn;
                        if (w_hdr_count == 16'd0) r_done <= 1'b1;
                        else if (w_too_big)       r_err  <= 1'b1;
                    end
                    DATA: begin
                        if (r_bcnt == 2'd3) begin
                            r_wdata <= {r_part, bus.ByteIn};
                            r_waddr <= BASE_ADDR + {{(30-IDXW){1'b0}}, r_idx, 2'b00};
                            r_we    <= 1'b1;
                            r_idx   <= r_idx + IDXW'(1);
                            r_bcnt  <= 2'd0;
                        end else begin
                            r_part <= {r_part[15:0], bus.ByteIn};
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (r_state == DONE) begin
                // Reached only after the final strobe cycle, so Done trails WriteEnable by one.
                r_done <= 1'b1;
            end
        end
    end

    assign bus.WriteAddress = r_waddr;
    assign bus.WriteData    = r_wdata;
    assign bus.WriteEnable  = r_we;
    assign bus.Done         = r_done;
    assign bus.Error        = r_err;
    assign bus.CpuHold      = ~r_done;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of images plus hand-written corner sequences,
// with expected memory writes queued as stimulus is driven and checked on each strobe.
module tb_inst_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sb[$];

    inst_mem_loader_if bus();

    inst_mem_loader dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hdr;
        logic [31:0] seed;
        int          gap;
        logic        exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] gen(input logic [31:0] s, input int i);
        return s ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (!rst && bus.WriteEnable) begin
            if (sb.size() == 0) begin
                chk("spurious_we_addr", bus.WriteAddress, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("we_addr", bus.WriteAddress, e[63:32]);
                chk("we_data", bus.WriteData, e[31:0]);
            end
        end
    end

    // Called right after a posedge; returns #1 after the accepting edge plus gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        @(posedge clk);
        #1;
        bus.ByteValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        sb.push_back({addr, w});
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic check_done(input string nm);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_done"}, {31'd0, bus.Done}, 32'd1);
        chk({nm, "_hold"}, {31'd0, bus.CpuHold}, 32'd0);
        chk({nm, "_rdy"}, {31'd0, bus.ByteReady}, 32'd0);
        chk({nm, "_pending"}, sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{hdr: 16'd1,     seed: 32'h1357_9BDF, gap: 0, exp_err: 1'b0};
        vt[1] = '{hdr: 16'd3,     seed: 32'hDEAD_BEEF, gap: 1, exp_err: 1'b0};
        vt[2] = '{hdr: 16'd256,   seed: 32'h0F0F_00FF, gap: 0, exp_err: 1'b0};
        vt[3] = '{hdr: 16'd257,   seed: 32'h0,         gap: 0, exp_err: 1'b1};
        vt[4] = '{hdr: 16'hFFFF,  seed: 32'h0,         gap: 0, exp_err: 1'b1};
        vt[5] = '{hdr: 16'd0,     seed: 32'h0,         gap: 0, exp_err: 1'b0};

        bus.Start = 1'b0; bus.ByteIn = 8'h00; bus.ByteValid = 1'b0;

        // Reset values
        #3;
        chk("rst_rdy",  {31'd0, bus.ByteReady}, 32'd0);
        chk("rst_hold", {31'd0, bus.CpuHold}, 32'd1);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_we",   {31'd0, bus.WriteEnable}, 32'd0);
        chk("rst_err",  {31'd0, bus.Error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-word image with exact Done timing
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h0232_4020, 32'h0, 0);
        send_word(32'h8E28_001C, 32'h4, 0);
        @(negedge clk);
        chk("img2_we_cycle_done", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        chk("img2_done", {31'd0, bus.Done}, 32'd1);
        chk("img2_hold", {31'd0, bus.CpuHold}, 32'd0);
        chk("img2_we_low", {31'd0, bus.WriteEnable}, 32'd0);
        chk("img2_addr_hold", bus.WriteAddress, 32'h4);
        chk("img2_data_hold", bus.WriteData, 32'h8E28_001C);
        @(posedge clk); #1;

        // Table of images
        for (int v = 0; v < 6; v++) begin
            pulse_start();
            send_byte(vt[v].hdr[15:8], 0);
            send_byte(vt[v].hdr[7:0], 0);
            if (vt[v].exp_err) begin
                @(negedge clk);
                chk("tbl_err", {31'd0, bus.Error}, 32'd1);
                chk("tbl_err_done", {31'd0, bus.Done}, 32'd0);
                chk("tbl_err_rdy", {31'd0, bus.ByteReady}, 32'd0);
                @(posedge clk); #1;
            end else begin
                for (int i = 0; i < int'(vt[v].hdr); i++)
                    send_word(gen(vt[v].seed, i), 32'(i) * 32'd4, vt[v].gap);
                if (vt[v].hdr == 16'd0) begin
                    @(negedge clk);
                    chk("tbl_zero_done", {31'd0, bus.Done}, 32'd1);
                    chk("tbl_zero_rdy", {31'd0, bus.ByteReady}, 32'd0);
                    @(posedge clk); #1;
                end else begin
                    check_done("tbl");
                end
            end
        end

        // Idle gaps inside a word
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 3);
        send_byte(8'hBB, 3);
        send_byte(8'hCC, 0);
        sb.push_back({32'h0, 32'hAABB_CCDD});
        send_byte(8'hDD, 0);
        check_done("gaps");

        // Start discards a partial word mid-image
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'h0102_0304, 32'h0, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h1122_3344, 32'h0, 0);
        check_done("abort");

        // Error then recovery
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("err_flag", {31'd0, bus.Error}, 32'd1);
        chk("err_rdy", {31'd0, bus.ByteReady}, 32'd0);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("err_clr", {31'd0, bus.Error}, 32'd0);
        chk("err_rdy_back", {31'd0, bus.ByteReady}, 32'd1);
        @(posedge clk); #1;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h5A5A_A5A5, 32'h0, 0);
        check_done("recover");

        // Asynchronous reset mid-word
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we",   {31'd0, bus.WriteEnable}, 32'd0);
        chk("arst_done", {31'd0, bus.Done}, 32'd0);
        chk("arst_hold", {31'd0, bus.CpuHold}, 32'd1);
        chk("arst_rdy",  {31'd0, bus.ByteReady}, 32'd0);
        chk("arst_addr", bus.WriteAddress, 32'h0);
        chk("arst_data", bus.WriteData, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFE_F00D, 32'h0, 0);
        check_done("arst_reload");

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
